// File: rtl/portao_pkg.sv
// Shared definitions for the gate controller: state encoding and direction flag.
package portao_pkg;

  localparam int ST_W = 3;

  typedef enum logic [ST_W-1:0] {
    ST_CLOSED  = 3'd0,
    ST_OPENING = 3'd1,
    ST_OPEN    = 3'd2,
    ST_CLOSING = 3'd3,
    ST_STOPPED = 3'd4,
    ST_FAULT   = 3'd5
  } state_t;

  localparam logic DIR_CLOSE = 1'b0;
  localparam logic DIR_OPEN  = 1'b1;

endpackage

// File: rtl/portao_timer.sv
// Saturating cycle counter used to time movement and the open dwell period.
module portao_timer #(
  parameter int TIMER_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic               en,
  output logic [TIMER_W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && (count != {TIMER_W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/portao_ctrl.sv
// Moore FSM gate controller: button, limit switches, obstacle reversal, timeout fault.
// Optional auto-close from OPEN is enabled by defining PORTAO_AUTO_CLOSE_EN.
module portao_ctrl
  import portao_pkg::*;
#(
  parameter int MOVE_TIMEOUT   = 50,
  parameter int AUTO_CLOSE_CYC = 100,
  parameter int TIMER_W        = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            btn,
  input  logic            sens_open,
  input  logic            sens_closed,
  input  logic            obstacle,
  output logic            motor_open,
  output logic            motor_close,
  output logic            light,
  output logic            fault,
  output logic [ST_W-1:0] state
);

  if (MOVE_TIMEOUT < 2 || (2 ** TIMER_W) <= MOVE_TIMEOUT ||
      (2 ** TIMER_W) <= AUTO_CLOSE_CYC) begin : g_bad_params
    $error("portao_ctrl: timer parameters out of range");
  end

  localparam logic [TIMER_W-1:0] MOVE_LAST = TIMER_W'(MOVE_TIMEOUT - 1);

  state_t               state_q, state_d;
  logic                 btn_q;
  logic                 last_dir_q, last_dir_d;
  logic                 btn_rise;
  logic                 tmr_clr, tmr_en;
  logic [TIMER_W-1:0]   tmr_count;

  assign btn_rise = btn & ~btn_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_CLOSED;
      btn_q      <= 1'b0;
      last_dir_q <= DIR_CLOSE;
    end else begin
      state_q    <= state_d;
      btn_q      <= btn;
      last_dir_q <= last_dir_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    last_dir_d = last_dir_q;
    // Conflicting limit switches mean a broken sensor: stop everything.
    if (state_q != ST_FAULT && sens_open && sens_closed) begin
      state_d = ST_FAULT;
    end else begin
      case (state_q)
        ST_CLOSED: begin
          if (btn_rise) state_d = ST_OPENING;
        end
        ST_OPENING: begin
          if (sens_open) begin
            state_d = ST_OPEN;
          end else if (btn_rise) begin
            state_d    = ST_STOPPED;
            last_dir_d = DIR_OPEN;
          end else if (tmr_count == MOVE_LAST) begin
            state_d = ST_FAULT;
          end
        end
        ST_OPEN: begin
`ifdef PORTAO_AUTO_CLOSE_EN
          if (btn_rise || (tmr_count == TIMER_W'(AUTO_CLOSE_CYC - 1) && !obstacle))
            state_d = ST_CLOSING;
`else
          if (btn_rise) state_d = ST_CLOSING;
`endif
        end
        ST_CLOSING: begin
          if (obstacle) begin
            state_d = ST_OPENING;
          end else if (sens_closed) begin
            state_d = ST_CLOSED;
          end else if (btn_rise) begin
            state_d    = ST_STOPPED;
            last_dir_d = DIR_CLOSE;
          end else if (tmr_count == MOVE_LAST) begin
            state_d = ST_FAULT;
          end
        end
        ST_STOPPED: begin
          if (btn_rise) state_d = (last_dir_q == DIR_CLOSE) ? ST_OPENING : ST_CLOSING;
        end
        default: state_d = ST_FAULT;
      endcase
    end
  end

  // The dwell timer restarts on every state change.
`ifdef PORTAO_AUTO_CLOSE_EN
  assign tmr_clr = (state_d != state_q) || (state_q == ST_OPEN && obstacle);
`else
  assign tmr_clr = (state_d != state_q);
`endif
  assign tmr_en = (state_q == ST_OPENING) || (state_q == ST_CLOSING) || (state_q == ST_OPEN);

  portao_timer #(.TIMER_W(TIMER_W)) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (tmr_clr),
    .en    (tmr_en),
    .count (tmr_count)
  );

  always_comb begin
    motor_open  = 1'b0;
    motor_close = 1'b0;
    light       = 1'b0;
    fault       = 1'b0;
    case (state_q)
      ST_OPENING: begin
        motor_open = 1'b1;
        light      = 1'b1;
      end
      ST_OPEN:    light = 1'b1;
      ST_CLOSING: begin
        motor_close = 1'b1;
        light       = 1'b1;
      end
      ST_FAULT: begin
        light = 1'b1;
        fault = 1'b1;
      end
      default: ;
    endcase
  end

  assign state = state_q;

endmodule
